// File: rtl/viterbi_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_decoder_if
// Description : Symbol-in / bit-out handshake bundle for viterbi_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface viterbi_decoder_if;
    logic       enable_i;
    logic [1:0] d_in;
    logic       ready_o;
    logic       valid_o;
    logic       d_out;

    modport master (output enable_i, d_in, input ready_o, valid_o, d_out);
    modport slave  (input enable_i, d_in, output ready_o, valid_o, d_out);
endinterface
`default_nettype wire

// File: rtl/viterbi_decoder.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_decoder
// Description : Hard-decision 8-state register-exchange Viterbi decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_decoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  wire logic        clk,
    input  wire logic        rst,
    viterbi_decoder_if.slave bus
);
    localparam int              CNT_W     = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0] C_PM_MAX  = '1;
    localparam logic [PM_W-1:0] C_PM_INIT = PM_W'(1) << (PM_W - 2);
    localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(TB_DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          best_q, best_d;
    logic [PM_W-1:0]     pm_q   [8];
    logic [PM_W-1:0]     pm_d   [8];
    logic [TB_DEPTH-1:0] surv_q [8];
    logic [TB_DEPTH-1:0] surv_d [8];
    logic                valid_q, valid_d;
    logic                d_out_q, d_out_d;

    logic [PM_W:0]       w_acs_pm  [8];
    logic [2:0]          w_acs_p   [8];
    logic                w_acs_bit [8];
    logic [PM_W-1:0]     w_norm    [8];
    logic [PM_W:0]       w_min;
    logic [2:0]          w_new_best;
    logic [2:0]          w_cur_best;
    logic                w_flush_bit;

    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
        return {1'b0, rx[0] ^ ex[0]} + {1'b0, rx[1] ^ ex[1]};
    endfunction

    // Predecessors of n are {n[1:0],b}; the bit that drives them into n is n[2]^n[0]^b.
    always_comb begin
        logic [2:0]    ns, p0, p1;
        logic          d0, d1;
        logic [PM_W:0] c0, c1;
        ns = '0; p0 = '0; p1 = '0; d0 = 1'b0; d1 = 1'b0; c0 = '0; c1 = '0;
        for (int n = 0; n < 8; n++) begin
            ns = 3'(n);
            p0 = {ns[1:0], 1'b0};
            p1 = {ns[1:0], 1'b1};
            d0 = ns[2] ^ ns[0];
            d1 = ~d0;
            c0 = {1'b0, pm_q[p0]} + (PM_W+1)'(branch_metric(bus.d_in, {d0 ^ ns[1] ^ ns[0], d0}));
            c1 = {1'b0, pm_q[p1]} + (PM_W+1)'(branch_metric(bus.d_in, {d1 ^ ns[1] ^ ns[0], d1}));
            if (c1 < c0) begin
                w_acs_pm[n]  = c1;
                w_acs_p[n]   = p1;
                w_acs_bit[n] = d1;
            end else begin
                w_acs_pm[n]  = c0;
                w_acs_p[n]   = p0;
                w_acs_bit[n] = d0;
            end
        end
    end

    always_comb begin
        w_min      = w_acs_pm[0];
        w_new_best = 3'd0;
        for (int n = 1; n < 8; n++) begin
            if (w_acs_pm[n] < w_min) begin
                w_min      = w_acs_pm[n];
                w_new_best = 3'(n);
            end
        end
    end

    always_comb begin
        logic [PM_W:0] diff;
        diff = '0;
        for (int n = 0; n < 8; n++) begin
            diff = w_acs_pm[n] - w_min;
            w_norm[n] = (diff > {1'b0, C_PM_MAX}) ? C_PM_MAX : diff[PM_W-1:0];
        end
    end

    always_comb begin
        w_cur_best = 3'd0;
        for (int n = 1; n < 8; n++) begin
            if (pm_q[n] < pm_q[w_cur_best]) w_cur_best = 3'(n);
        end
    end

    always_comb begin
        w_flush_bit = 1'b0;
        for (int i = 0; i < TB_DEPTH; i++) begin
            if (CNT_W'(i + 1) == cnt_q) w_flush_bit = surv_q[best_q][i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        pm_d    = pm_q;
        surv_d  = surv_q;
        valid_d = 1'b0;
        d_out_d = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (bus.enable_i) begin
                    state_d = S_RUN;
                    for (int n = 0; n < 8; n++) begin
                        pm_d[n]   = w_norm[n];
                        surv_d[n] = {surv_q[w_acs_p[n]][TB_DEPTH-2:0], w_acs_bit[n]};
                    end
                    if (cnt_q == C_DEPTH) begin
                        valid_d = 1'b1;
                        d_out_d = surv_q[w_acs_p[w_new_best]][TB_DEPTH-1];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (state_q == S_RUN) begin
                    // Frame ended: cnt doubles as the flush down-counter.
                    state_d = S_FLUSH;
                    best_d  = w_cur_best;
                end
            end
            S_FLUSH: begin
                valid_d = 1'b1;
                d_out_d = w_flush_bit;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    for (int n = 0; n < 8; n++) begin
                        pm_d[n]   = (n == 0) ? '0 : C_PM_INIT;
                        surv_d[n] = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            best_q  <= '0;
            valid_q <= 1'b0;
            d_out_q <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                pm_q[n]   <= (n == 0) ? '0 : C_PM_INIT;
                surv_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            valid_q <= valid_d;
            d_out_q <= d_out_d;
            pm_q    <= pm_d;
            surv_q  <= surv_d;
        end
    end

    assign bus.ready_o = (state_q != S_FLUSH);
    assign bus.valid_o = valid_q;
    assign bus.d_out   = d_out_q;
endmodule
`default_nettype wire
